rs_issue_scheduler: RTL and testbench
=====================================

# rs_issue_scheduler

Issue scheduler for the 16-entry reservation station. Each cycle it selects up to four entries whose sources are ready and routes them to the functional units: ALU0, ALU1, MEM and an unpipelined MUL. Selection is oldest-first. Grants are registered, and the station frees the granted entries from the one-hot issued mask.

## Interface
- RS_DEPTH, 16: reservation station entries; index width is $clog2(RS_DEPTH).
- AGE_W, 4: width of the per-entry age counter.
- MUL_LAT, 4: MUL occupancy in cycles after an issue.
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high; dominates all other inputs.
- flush  in  1  pipeline flush; synchronous.
- entryValid  in  RS_DEPTH  entry holds an instruction.
- entryReady  in  RS_DEPTH  both source operands of the entry are ready.
- entryAlloc  in  RS_DEPTH  entry is being written this cycle.
- entryFuType  in  RS_DEPTH x 2  fuType_t per entry: 0 ALU, 1 MEM, 2 MUL, 3 reserved (never issued).
- aluRdy  in  2  ALU0/ALU1 can accept an instruction.
- memRdy  in  1  MEM can accept an instruction.
- mulRdy  in  1  MUL can accept an instruction.
- issue  out  4 x issuePort_t  {valid, idx} per port; order ALU0, ALU1, MEM, MUL.
- entryIssued  out  RS_DEPTH  one-hot OR of all granted entries; the station clears these.

## Operation
- Candidates: entryValid & entryReady & ~entryAlloc & ~pending.
  - pending is the mask of entries granted in the previous cycle.
  - Masking pending prevents double issue while the station clears those entries.
- Port selection runs in fixed order, each port picking the oldest eligible candidate:
  - ALU0 picks from ALU candidates when aluRdy[0].
  - ALU1 picks from the remaining ALU candidates when aluRdy[1].
  - MEM picks from MEM candidates when memRdy.
  - MUL picks from MUL candidates when mulRdy and mulBusy == 0.
- Oldest means the largest age; ties go to the lowest index.
- An entry is granted to at most one port.
- Age counters:
  - Cleared to 0 on entryAlloc.
  - Otherwise incremented each cycle while entryValid and not granted.
  - Saturate at 2^AGE_W-1.
  - Cleared when the entry is granted.
- mulBusy counter:
  - Loads MUL_LAT-1 on a MUL grant.
  - Decrements to 0 each cycle.
  - A new MUL grant is possible only when it reads 0.
- flush:
  - Next cycle, all issue valids and entryIssued are 0.
  - pending and all ages are cleared.
  - No grant is made in the flush cycle.
  - mulBusy keeps counting, because the unit is still occupied.
- Reset clears all outputs, pending, ages and mulBusy to 0.

## Timing
- Selection is combinational on the current inputs and state.
- issue and entryIssued are registered: a grant decided in cycle t is visible in cycle t+1 for exactly one cycle.
- pending(t+1) = entryIssued(t+1). Those entries are ineligible in cycle t+1 even if entryValid is still 1.
- An entry allocated in cycle t first becomes eligible in cycle t+1.
- FU ready signals are sampled in the selection cycle; the scheduler has no retry or backpressure after a grant.
- MUL back-to-back issue spacing is MUL_LAT cycles.
- When reset and flush are both high, reset wins.
- A reset asserted mid-operation discards all grants of that cycle.

## Configuration
- SCHED_AGE_EN defined: oldest-first selection with per-entry age counters, as described above.
- SCHED_AGE_EN undefined:
  - The age counters are not instantiated.
  - Every port picks the lowest-index eligible candidate.
  - All other behaviour (pending, mulBusy, flush, timing) is unchanged.

## Structure
- Shared package holds: fuType_t enum, issuePort_t struct {valid, idx}, port index constants (PORT_ALU0..PORT_MUL), and the reset value of issuePort_t.
- Sub-module rs_select_oldest:
  - Inputs: candidate mask and age vector.
  - Outputs: found flag and index; lowest index wins ties, and selection is pure index priority when ages are absent.
  - Instantiated four times in a chain; each instance's mask excludes the earlier grants.

## Test plan
- Reset, then entries 3 and 7, both ALU, valid and ready, with aluRdy=2'b11 → next cycle ALU0 idx 3 and ALU1 idx 7; entryIssued=0x0088.
- Entry 9 allocated 5 cycles before entry 2, both ALU, only aluRdy[0] → ALU0 issues 9 (entry 2 when SCHED_AGE_EN is undefined).
- Two MUL entries 4 and 5 ready, mulRdy=1, MUL_LAT=4 → MUL issues 4 at cycle t+1 and 5 at cycle t+5; no MUL grant in between.
- Entry 6 granted while the station holds entryValid[6] one extra cycle → entry 6 is not issued twice; entryIssued[6] is high for a single cycle.
- flush asserted with entries 1 (MEM) and 2 (ALU) ready and memRdy=1 → all issue valids 0 and entryIssued=0 next cycle; issue resumes the cycle after flush deasserts.
- reset asserted in the same cycle as flush and pending grants → all outputs 0 next cycle; ages and mulBusy read 0.

Source files
------------

// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and constants for the reservation-station issue scheduler.
// Optional feature macro: SCHED_AGE_EN (oldest-first selection via per-entry ages).
package rs_issue_scheduler_pkg;

    localparam int RS_DEPTH  = 16;
    localparam int IDX_W     = $clog2(RS_DEPTH);
    localparam int AGE_W     = 4;
    localparam int MUL_LAT   = 4;
    // Busy counter only ever holds MUL_LAT-1 down to 0; MUL_LAT must be >= 2.
    localparam int BUSY_W    = $clog2(MUL_LAT);
    localparam int NUM_PORTS = 4;

    // Issue port order on the issue output.
    localparam int PORT_ALU0 = 0;
    localparam int PORT_ALU1 = 1;
    localparam int PORT_MEM  = 2;
    localparam int PORT_MUL  = 3;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MEM  = 2'd1,
        FU_MUL  = 2'd2,
        FU_RSVD = 2'd3   // never issued
    } fuType_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } issuePort_t;

    localparam issuePort_t ISSUE_PORT_RESET = '{valid: 1'b0, idx: '0};

    // Mask of entries whose FU type equals kind.
    function automatic logic [RS_DEPTH-1:0] fuMatch(
        input logic [RS_DEPTH-1:0][1:0] fuType,
        input fuType_t                  kind
    );
        logic [RS_DEPTH-1:0] m;
        for (int i = 0; i < RS_DEPTH; i++) begin
            m[i] = (fuType[i] == kind);
        end
        return m;
    endfunction

    // One-hot vector for a selector result (all zero when nothing was found).
    function automatic logic [RS_DEPTH-1:0] oneHot(
        input logic             found,
        input logic [IDX_W-1:0] idx
    );
        logic [RS_DEPTH-1:0] m;
        m = '0;
        if (found) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rs_select_oldest.sv
// Picks one entry from a candidate mask: largest age wins, lowest index breaks
// ties. Without SCHED_AGE_EN there is no age input and selection is pure
// lowest-index priority.
module rs_select_oldest
    import rs_issue_scheduler_pkg::*;
(
    input  logic [RS_DEPTH-1:0]            mask,
`ifdef SCHED_AGE_EN
    input  logic [RS_DEPTH-1:0][AGE_W-1:0] ages,
`endif
    output logic                           found,
    output logic [IDX_W-1:0]               idx
);

`ifdef SCHED_AGE_EN
    logic [AGE_W-1:0] bestAge;
`endif

    // Linear scan; a strictly larger age is required to displace an earlier pick.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        found = 1'b0;
        idx   = '0;
`ifdef SCHED_AGE_EN
        bestAge = '0;
`endif
        for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef SCHED_AGE_EN
            if (mask[i] && (!found || ages[i] > bestAge)) begin
                found   = 1'b1;
                idx     = IDX_W'(i);
                bestAge = ages[i];
            end
`else
            if (mask[i] && !found) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
`endif
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Issue scheduler for the 16-entry reservation station. Selects up to four
// ready entries per cycle for ALU0, ALU1, MEM and the unpipelined MUL, and
// registers the grants. Optional feature macro: SCHED_AGE_EN.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [RS_DEPTH-1:0]            entryValid,
    input  logic [RS_DEPTH-1:0]            entryReady,
    input  logic [RS_DEPTH-1:0]            entryAlloc,
    input  logic [RS_DEPTH-1:0][1:0]       entryFuType,
    input  logic [1:0]                     aluRdy,
    input  logic                           memRdy,
    input  logic                           mulRdy,
    output issuePort_t [NUM_PORTS-1:0]     issue,
    output logic [RS_DEPTH-1:0]            entryIssued
);

    logic [RS_DEPTH-1:0] pending;
    logic [RS_DEPTH-1:0] cand, aluCand, memCand, mulCand;
    logic [BUSY_W-1:0]   mulBusy;

    // Per-port selector masks and results, kept as separate nets so the
    // chain of exclusions stays a clean combinational path.
    logic [RS_DEPTH-1:0] mask0, mask1, mask2, mask3;
    logic [RS_DEPTH-1:0] taken0, taken1, taken2, grantMask;
    logic                found0, found1, found2, found3;
    logic [IDX_W-1:0]    idx0, idx1, idx2, idx3;

    // Entries granted last cycle are still held by the station while it clears them.
    assign pending = entryIssued;

    assign cand    = entryValid & entryReady & ~entryAlloc & ~pending;
    assign aluCand = cand & fuMatch(entryFuType, FU_ALU);
    assign memCand = cand & fuMatch(entryFuType, FU_MEM);
    assign mulCand = cand & fuMatch(entryFuType, FU_MUL);

    // Fixed port order; each later port excludes what earlier ports took.
    assign mask0  = aluRdy[0] ? aluCand : '0;
    assign taken0 = oneHot(found0, idx0);
    assign mask1  = aluRdy[1] ? (aluCand & ~taken0) : '0;
    assign taken1 = taken0 | oneHot(found1, idx1);
    assign mask2  = memRdy ? (memCand & ~taken1) : '0;
    assign taken2 = taken1 | oneHot(found2, idx2);
    assign mask3  = (mulRdy && mulBusy == '0) ? (mulCand & ~taken2) : '0;
    assign grantMask = taken2 | oneHot(found3, idx3);

`ifdef SCHED_AGE_EN
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
    logic [RS_DEPTH-1:0][AGE_W-1:0] ages;

    // Per-entry age: cleared on alloc, grant, flush or reset; saturating count while waiting.
    always_ff @(posedge clk) begin
        // NOTE: the age array is reset deliberately; a stale age would bias selection after reset.
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (reset || flush || entryAlloc[i] || grantMask[i]) begin
                ages[i] <= '0;
            end else if (entryValid[i] && ages[i] != AGE_MAX) begin
                ages[i] <= ages[i] + AGE_W'(1);
            end
        end
    end
`endif

    rs_select_oldest uSelAlu0 (
        .mask  (mask0),
`ifdef SCHED_AGE_EN
        .ages  (ages),
`endif
        .found (found0),
        .idx   (idx0)
    );

    rs_select_oldest uSelAlu1 (
        .mask  (mask1),
`ifdef SCHED_AGE_EN
        .ages  (ages),
`endif
        .found (found1),
        .idx   (idx1)
    );

    rs_select_oldest uSelMem (
        .mask  (mask2),
`ifdef SCHED_AGE_EN
        .ages  (ages),
`endif
        .found (found2),
        .idx   (idx2)
    );

    rs_select_oldest uSelMul (
        .mask  (mask3),
`ifdef SCHED_AGE_EN
        .ages  (ages),
`endif
        .found (found3),
        .idx   (idx3)
    );

    // Register the grants; flush and reset both suppress this cycle's grants.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || flush) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                issue[p] <= ISSUE_PORT_RESET;
            end
            entryIssued <= '0;
        end else begin
            issue[PORT_ALU0] <= '{valid: found0, idx: idx0};
            issue[PORT_ALU1] <= '{valid: found1, idx: idx1};
            issue[PORT_MEM]  <= '{valid: found2, idx: idx2};
            issue[PORT_MUL]  <= '{valid: found3, idx: idx3};
            entryIssued      <= grantMask;
        end
    end

    // MUL occupancy: load on grant, count down to 0; keeps counting through flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            mulBusy <= '0;
        end else if (found3 && !flush) begin
            mulBusy <= BUSY_W'(MUL_LAT - 1);
        end else if (mulBusy != '0) begin
            mulBusy <= mulBusy - BUSY_W'(1);
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: directed scenarios with literal
// expectations, then randomized station traffic checked every cycle against a
// behavioural model. Honours SCHED_AGE_EN the same way the design does.
module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

`ifdef SCHED_AGE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       flush;
    logic [RS_DEPTH-1:0]        entryValid;
    logic [RS_DEPTH-1:0]        entryReady;
    logic [RS_DEPTH-1:0]        entryAlloc;
    logic [RS_DEPTH-1:0][1:0]   entryFuType;
    logic [1:0]                 aluRdy;
    logic                       memRdy;
    logic                       mulRdy;
    issuePort_t [NUM_PORTS-1:0] issue;
    logic [RS_DEPTH-1:0]        entryIssued;

    int vectors     = 0;
    int miscompares = 0;

    rs_issue_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .entryValid  (entryValid),
        .entryReady  (entryReady),
        .entryAlloc  (entryAlloc),
        .entryFuType (entryFuType),
        .aluRdy      (aluRdy),
        .memRdy      (memRdy),
        .mulRdy      (mulRdy),
        .issue       (issue),
        .entryIssued (entryIssued)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    issuePort_t          expIssue [NUM_PORTS];
    issuePort_t          nIssue   [NUM_PORTS];
    logic [RS_DEPTH-1:0] expIssued = '0;
    logic [RS_DEPTH-1:0] mCand, mGrant;
    int                  mAge [RS_DEPTH];
    int                  mBusy = 0;
    bit                  armed = 1'b0;

    // Oldest eligible entry of type ft (lowest index on equal age), or -1.
    function automatic int pickBest(input logic [RS_DEPTH-1:0] mask, input int ft);
        int best = -1;
        int bestKey = -1;
        for (int i = 0; i < RS_DEPTH; i++) begin
            int key = AGE_EN ? mAge[i] : 0;
            if (mask[i] && int'(entryFuType[i]) == ft && (best < 0 || key > bestKey)) begin
                best = i;
                bestKey = key;
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) expIssue[p] = '0;
            expIssued = '0;
            mBusy = 0;
            for (int i = 0; i < RS_DEPTH; i++) mAge[i] = 0;
            armed = 1'b1;
        end else begin
            mCand  = entryValid & entryReady & ~entryAlloc & ~expIssued;
            mGrant = '0;
            for (int p = 0; p < NUM_PORTS; p++) nIssue[p] = '0;
            if (!flush) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    bit ok;
                    int ft;
                    int b;
                    case (p)
                        0:       begin ok = aluRdy[0];             ft = 0; end
                        1:       begin ok = aluRdy[1];             ft = 0; end
                        2:       begin ok = memRdy;                ft = 1; end
                        default: begin ok = mulRdy && mBusy == 0;  ft = 2; end
                    endcase
                    if (ok) begin
                        b = pickBest(mCand & ~mGrant, ft);
                        if (b >= 0) begin
                            nIssue[p].valid = 1'b1;
                            nIssue[p].idx   = IDX_W'(b);
                            mGrant[b] = 1'b1;
                        end
                    end
                end
            end
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (flush || entryAlloc[i] || mGrant[i]) mAge[i] = 0;
                else if (entryValid[i]) mAge[i] = (mAge[i] < (1 << AGE_W) - 1) ? mAge[i] + 1 : mAge[i];
            end
            if (nIssue[PORT_MUL].valid) mBusy = MUL_LAT - 1;
            else if (mBusy > 0) mBusy = mBusy - 1;
            for (int p = 0; p < NUM_PORTS; p++) expIssue[p] = nIssue[p];
            expIssued = mGrant;
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (armed) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                check($sformatf("model issue[%0d]", p), 64'(issue[p]), 64'(expIssue[p]));
            end
            check("model entryIssued", 64'(entryIssued), 64'(expIssued));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        entryValid = '0;
        entryReady = '0;
        entryAlloc = '0;
        entryFuType = '0;
        aluRdy = 2'b00;
        memRdy = 1'b0;
        mulRdy = 1'b0;
    endtask

    function automatic logic [63:0] port(input logic v, input int idx);
        issuePort_t ip;
        ip.valid = v;
        ip.idx = IDX_W'(idx);
        return 64'(ip);
    endfunction

    logic [RS_DEPTH-1:0] gr, lateFree;
    bit                  prevClear;

    initial begin
        idle();
        reset = 1'b1;
        cyc(); cyc();
        check("reset entryIssued", 64'(entryIssued), 64'h0);
        check("reset issue", 64'(issue), 64'h0);
        check("reset mulBusy", 64'(dut.mulBusy), 64'h0);
        reset = 1'b0;

        // Two ALU entries, both ALU ports ready.
        entryValid[3] = 1'b1; entryReady[3] = 1'b1;
        entryValid[7] = 1'b1; entryReady[7] = 1'b1;
        aluRdy = 2'b11;
        cyc();
        check("t1 alu0", 64'(issue[PORT_ALU0]), port(1'b1, 3));
        check("t1 alu1", 64'(issue[PORT_ALU1]), port(1'b1, 7));
        check("t1 entryIssued", 64'(entryIssued), 64'h0088);
        check("t1 model pin", 64'(expIssued), 64'h0088);
        idle(); cyc();

        // Entry 9 allocated 5 cycles before entry 2; only ALU0 ready.
        entryAlloc[9] = 1'b1; entryValid[9] = 1'b1;
        cyc();
        entryAlloc = '0;
        repeat (4) cyc();
        entryAlloc[2] = 1'b1; entryValid[2] = 1'b1;
        cyc();
        entryAlloc = '0;
        entryReady[9] = 1'b1; entryReady[2] = 1'b1;
        aluRdy = 2'b01;
        cyc();
        check("t2 alu0 age", 64'(issue[PORT_ALU0]), port(1'b1, AGE_EN ? 9 : 2));
        check("t2 alu1 idle", 64'(issue[PORT_ALU1]), port(1'b0, 0));
        idle(); cyc();

        // MUL spacing: entries 4 and 5.
        entryFuType[4] = 2'd2; entryValid[4] = 1'b1; entryReady[4] = 1'b1;
        entryFuType[5] = 2'd2; entryValid[5] = 1'b1; entryReady[5] = 1'b1;
        mulRdy = 1'b1;
        cyc();
        check("t3 mul first", 64'(issue[PORT_MUL]), port(1'b1, 4));
        entryValid[4] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t3 mul gap", 64'(issue[PORT_MUL].valid), 64'h0);
        end
        cyc();
        check("t3 mul second", 64'(issue[PORT_MUL]), port(1'b1, 5));
        idle(); cyc();

        // Entry 6 held valid one extra cycle after its grant.
        entryValid[6] = 1'b1; entryReady[6] = 1'b1; aluRdy = 2'b01;
        cyc();
        check("t4 grant", 64'(entryIssued), 64'h0040);
        cyc();
        check("t4 pending blocks", 64'(entryIssued), 64'h0);
        check("t4 no reissue", 64'(issue[PORT_ALU0].valid), 64'h0);
        entryValid[6] = 1'b0;
        cyc();
        check("t4 quiet", 64'(entryIssued), 64'h0);
        idle(); cyc();

        // Flush suppresses grants; issue resumes after it drops.
        entryFuType[1] = 2'd1; entryValid[1] = 1'b1; entryReady[1] = 1'b1;
        entryValid[2] = 1'b1; entryReady[2] = 1'b1;
        memRdy = 1'b1; aluRdy = 2'b11; flush = 1'b1;
        cyc();
        check("t5 flush issue", 64'(issue), 64'h0);
        check("t5 flush entryIssued", 64'(entryIssued), 64'h0);
        flush = 1'b0;
        cyc();
        check("t5 mem", 64'(issue[PORT_MEM]), port(1'b1, 1));
        check("t5 alu0", 64'(issue[PORT_ALU0]), port(1'b1, 2));
        check("t5 entryIssued", 64'(entryIssued), 64'h0006);
        idle(); cyc();

        // Reset together with flush while grants are pending.
        entryValid[1] = 1'b1; entryReady[1] = 1'b1;
        entryFuType[4] = 2'd2; entryValid[4] = 1'b1; entryReady[4] = 1'b1;
        aluRdy = 2'b01; mulRdy = 1'b1;
        cyc();
        check("t6 pending grants", 64'(entryIssued), 64'h0012);
        reset = 1'b1; flush = 1'b1;
        cyc();
        check("t6 issue", 64'(issue), 64'h0);
        check("t6 entryIssued", 64'(entryIssued), 64'h0);
        check("t6 mulBusy", 64'(dut.mulBusy), 64'h0);
`ifdef SCHED_AGE_EN
        check("t6 ages", 64'(dut.ages), 64'h0);
`endif
        reset = 1'b0;
        idle(); cyc();

        // Randomized station traffic.
        lateFree = '0;
        prevClear = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            gr = expIssued;
            entryValid = entryValid & ~lateFree;
            lateFree = '0;
            if (prevClear) begin
                entryValid = '0;
                entryReady = '0;
            end
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (gr[i] && !prevClear) begin
                    if ($urandom_range(3) == 0) lateFree[i] = 1'b1;
                    else entryValid[i] = 1'b0;
                end
            end
            entryAlloc = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (!entryValid[i] && !gr[i] && $urandom_range(3) == 0) begin
                    entryAlloc[i]  = 1'b1;
                    entryValid[i]  = 1'b1;
                    entryReady[i]  = $urandom_range(1) == 1;
                    entryFuType[i] = 2'($urandom_range(3));
                end else if (entryValid[i] && !entryReady[i] && $urandom_range(2) == 0) begin
                    entryReady[i] = 1'b1;
                end
            end
            aluRdy = 2'($urandom_range(3));
            memRdy = $urandom_range(3) != 0;
            mulRdy = $urandom_range(3) != 0;
            flush  = $urandom_range(40) == 0;
            reset  = $urandom_range(150) == 0;
            prevClear = flush || reset;
            cyc();
        end
        reset = 1'b0;
        idle();
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
